// File: rtl/ddr_region_preloader_pkg.sv
// Shared types for the DDR region preloader.
// Region mode encodings and FSM state codes.
package ddr_region_preloader_pkg;

  typedef enum logic [1:0] {
    MODE_STREAM = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_CONST  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_SPLIT,
    S_DONE
  } state_e;

  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr_region_preloader_serializer.sv
// Splits one wide source word into narrow beats, LSB first,
// with a valid/ready beat handshake and a last-beat flag.
module ddr_region_preloader_serializer
  import ddr_region_preloader_pkg::*;
#(
  parameter int PW = 128,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [PW-1:0] word_i,
  output logic [DW-1:0] beat_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          last_o
);

  localparam int BPW = PW / DW;
  localparam int CW  = idx_w(BPW);

  logic [PW-1:0] word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;

  assign last_o  = (cnt_q == CW'(BPW - 1));
  assign beat_o  = word_q[DW-1:0];
  assign valid_o = valid_q;

  always_comb begin
    word_d  = word_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      word_d  = word_i;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      if (last_o) begin
        valid_d = 1'b0;
      end else begin
        word_d = word_q >> DW;
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/ddr_region_preloader.sv
// Multi-region DDR preload engine: walks a latched region table,
// fetches/synthesises words and writes them out as DDR beats.
module ddr_region_preloader
  import ddr_region_preloader_pkg::*;
#(
  parameter int                    NUM_REGIONS    = 5,
  parameter int                    PORT_DATAWIDTH = 128,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    TX_SIZE_WIDTH  = 20,
  parameter logic [ADDR_WIDTH-1:0] DDR_BASE       = 32'h0800_0000
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [NUM_REGIONS*ADDR_WIDTH-1:0]   cfg_base,
  input  logic [NUM_REGIONS*TX_SIZE_WIDTH-1:0] cfg_words,
  input  logic [NUM_REGIONS*2-1:0]            cfg_mode,
  input  logic [PORT_DATAWIDTH-1:0]           cfg_const,
  input  logic [PORT_DATAWIDTH-1:0]           src_data,
  input  logic                                src_valid,
  output logic                                src_ready,
  output logic [idx_w(NUM_REGIONS)-1:0]       src_region,
  output logic [TX_SIZE_WIDTH-1:0]            wr_addr,
  output logic [DATA_WIDTH-1:0]               wr_data,
  output logic                                wr_valid,
  input  logic                                wr_ready,
  output logic                                busy,
  output logic                                done,
  output logic                                err_range
);

  localparam int BPW = PORT_DATAWIDTH / DATA_WIDTH;
  localparam int RW  = idx_w(NUM_REGIONS);
  localparam int XW  = ADDR_WIDTH + 1;
  localparam logic [XW-1:0] LIMIT =
    {{(ADDR_WIDTH-TX_SIZE_WIDTH){1'b0}}, 1'b1, {TX_SIZE_WIDTH{1'b0}}};

  state_e                    state_q, state_d;
  logic [RW-1:0]             region_q, region_d;
  logic [TX_SIZE_WIDTH-1:0]  word_q, word_d;
  logic [TX_SIZE_WIDTH-1:0]  addr_q, addr_d;
  logic                      err_q, err_d;

  logic [ADDR_WIDTH-1:0]     base_q  [NUM_REGIONS];
  logic [TX_SIZE_WIDTH-1:0]  words_q [NUM_REGIONS];
  logic [1:0]                mode_q  [NUM_REGIONS];
  logic [PORT_DATAWIDTH-1:0] const_q;
  logic                      cfg_latch;

  logic [ADDR_WIDTH-1:0]     cur_base;
  logic [TX_SIZE_WIDTH-1:0]  cur_words;
  mode_e                     cur_mode;
  logic [XW-1:0]             off_x, span_x, end_x;
  logic                      bad, skip, last_region;

  logic                      ser_load, ser_last, beat_hs;
  logic [PORT_DATAWIDTH-1:0] ser_word;
  logic [TX_SIZE_WIDTH-1:0]  word_inc;

  assign cur_base  = base_q[region_q];
  assign cur_words = words_q[region_q];
  assign cur_mode  = mode_e'(mode_q[region_q]);

  // End offset is checked one bit wider so a wrap cannot pass.
  assign off_x  = {1'b0, cur_base} - {1'b0, DDR_BASE};
  assign span_x = XW'(cur_words) * XW'(BPW);
  assign end_x  = off_x + span_x;
  assign bad    = (cur_mode == MODE_RSVD) ||
                  (cur_base < DDR_BASE) ||
                  (end_x > LIMIT);
  assign skip   = bad || (cur_words == '0);

  assign last_region = (region_q == RW'(NUM_REGIONS - 1));
  assign beat_hs     = wr_valid && wr_ready;
  assign word_inc    = word_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    word_d    = word_q;
    addr_d    = addr_q;
    err_d     = err_q;
    cfg_latch = 1'b0;
    ser_load  = 1'b0;
    ser_word  = '0;
    src_ready = 1'b0;
    if (beat_hs) addr_d = addr_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_latch = 1'b1;
          err_d     = 1'b0;
          region_d  = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        word_d = '0;
        addr_d = off_x[TX_SIZE_WIDTH-1:0];
        if (bad) err_d = 1'b1;
        if (!skip) begin
          state_d = S_FETCH;
        end else if (last_region) begin
          state_d = S_DONE;
        end else begin
          region_d = region_q + 1'b1;
        end
      end
      S_FETCH: begin
        unique case (1'b1)
          (cur_mode == MODE_STREAM): begin
            src_ready = 1'b1;
            if (src_valid) begin
              ser_load = 1'b1;
              ser_word = src_data;
              state_d  = S_SPLIT;
            end
          end
          default: begin
            ser_load = 1'b1;
            if (cur_mode == MODE_CONST && word_q == '0)
              ser_word = const_q;
            state_d = S_SPLIT;
          end
        endcase
      end
      S_SPLIT: begin
        if (beat_hs && ser_last) begin
          word_d = word_inc;
          if (word_inc != cur_words) begin
            state_d = S_FETCH;
          end else if (last_region) begin
            state_d = S_DONE;
          end else begin
            region_d = region_q + 1'b1;
            state_d  = S_LOAD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      region_q <= '0;
      word_q   <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      word_q   <= word_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGIONS; r++) begin
        base_q[r]  <= '0;
        words_q[r] <= '0;
        mode_q[r]  <= '0;
      end
      const_q <= '0;
    end else if (cfg_latch) begin
      for (int r = 0; r < NUM_REGIONS; r++) begin
        base_q[r]  <= cfg_base[r*ADDR_WIDTH +: ADDR_WIDTH];
        words_q[r] <= cfg_words[r*TX_SIZE_WIDTH +: TX_SIZE_WIDTH];
        mode_q[r]  <= cfg_mode[r*2 +: 2];
      end
      const_q <= cfg_const;
    end
  end

  ddr_region_preloader_serializer #(
    .PW (PORT_DATAWIDTH),
    .DW (DATA_WIDTH)
  ) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ser_load),
    .word_i  (ser_word),
    .beat_o  (wr_data),
    .valid_o (wr_valid),
    .ready_i (wr_ready),
    .last_o  (ser_last)
  );

  assign busy       = (state_q == S_LOAD) ||
                      (state_q == S_FETCH) ||
                      (state_q == S_SPLIT);
  assign done       = (state_q == S_DONE);
  assign src_region = region_q;
  assign wr_addr    = addr_q;
  assign err_range  = err_q;

endmodule
